// File: rtl/um_egress_dispatcher_pkg.sv
// um_egress_dispatcher_pkg: packet flags, rule field offsets and FSM states shared by the egress dispatcher
package um_egress_dispatcher_pkg;
  localparam int DATA_W = 139;
  localparam int RULE_W = 30;
  localparam int FLAG_LSB = 136;
  localparam logic [2:0] HEAD = 3'b101;
  localparam logic [2:0] BODY = 3'b100;
  localparam logic [2:0] TAIL = 3'b110;
  localparam int RULE_PORT_LSB = 0;
  localparam int RULE_PORT_W = 4;
  localparam int RULE_DROP_BIT = 4;
  typedef enum logic [1:0] {IDLE, DECIDE, SEND, DROP} state_t;
endpackage

// File: rtl/um_egress_fifo.sv
// um_egress_fifo: show-ahead fifo (q valid while !empty), async clear; ports clk, aclr, data/wrreq in, rdreq in, q/empty/usedw out, ovf pulses on a discarded write
module um_egress_fifo #(
  parameter int W = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic [W-1:0]  data,
  input  logic          wrreq,
  input  logic          rdreq,
  output logic [W-1:0]  q,
  output logic          empty,
  output logic [AW-1:0] usedw,
  output logic          ovf
);
  localparam int N = 1 << AW;
  logic [W-1:0] mem [N];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic full, wr, rd;
  assign full = cnt[AW];
  assign empty = cnt == '0;
  assign rd = rdreq && !empty;
  // a pop in the same cycle frees the slot, so a write into a full fifo is kept
  assign wr = wrreq && (!full || rd);
  assign ovf = wrreq && !wr;
  assign q = mem[rp];
  // usedw saturates at all-ones when every slot is occupied
  assign usedw = full ? '1 : cnt[AW-1:0];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= data;
  always_ff @(posedge clk or posedge aclr)
    if (aclr) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/um_egress_steer.sv
// um_egress_steer: registered one-hot demux; ports clk, reset (async active-low), fwd/port/data in, port_data/port_data_valid out (data holds on stall)
module um_egress_steer #(
  parameter int NPORT = 4,
  parameter int W = 139,
  parameter int PW = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fwd,
  input  logic [PW-1:0]    port,
  input  logic [W-1:0]     data,
  output logic [W-1:0]     port_data,
  output logic [NPORT-1:0] port_data_valid
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      port_data <= '0;
      port_data_valid <= '0;
    end else begin
      port_data_valid <= fwd ? NPORT'(1) << port : '0;
      if (fwd) port_data <= data;
    end
endmodule

// File: rtl/um_egress_dispatcher.sv
// um_egress_dispatcher: buffers UM packets and rules, pairs each rule with the next packet and steers it to an egress port or drops it.
//   ports: clk, reset (async active-low); rule in (um2cdp_rule_wrreq/um2cdp_rule), cdp2um_rule_usedw out;
//   packet in (um2cdp_data_valid/um2cdp_data), cdp2um_tx_enable out; port_ready in, port_data_valid/port_data out;
//   err_sticky {pkt overflow, rule overflow}; sent_cnt/drop_cnt built only with UM_EGRESS_STATS_EN defined, else tied to 0.
module um_egress_dispatcher
  import um_egress_dispatcher_pkg::*;
#(
  parameter int NPORT = 4,
  parameter int PKT_WORDS = 256,
  parameter int PKT_AFULL = 160,
  parameter int RULE_WORDS = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          um2cdp_rule_wrreq,
  input  logic [RULE_W-1:0]             um2cdp_rule,
  output logic [$clog2(RULE_WORDS)-1:0] cdp2um_rule_usedw,
  input  logic                          um2cdp_data_valid,
  input  logic [DATA_W-1:0]             um2cdp_data,
  output logic                          cdp2um_tx_enable,
  input  logic [NPORT-1:0]              port_ready,
  output logic [NPORT-1:0]              port_data_valid,
  output logic [DATA_W-1:0]             port_data,
  output logic [1:0]                    err_sticky,
  output logic [31:0]                   sent_cnt,
  output logic [31:0]                   drop_cnt
);
  localparam int PKT_DEPTH = $clog2(PKT_WORDS);
  localparam int RULE_DEPTH = $clog2(RULE_WORDS);
  localparam int PW = NPORT > 1 ? $clog2(NPORT) : 1;
  logic [DATA_W-1:0] q_pkt;
  logic [RULE_W-1:0] q_rule;
  logic pkt_empty, rule_empty, pkt_ovf, rule_ovf;
  logic [PKT_DEPTH-1:0] pkt_usedw;
  logic [RULE_DEPTH-1:0] rule_level;
  logic rule_pop, pkt_pop, fwd, tail, sent_done, drop_done, skip;
  logic [PW-1:0] port;
  state_t state;
  logic unused_rule;
  assign unused_rule = ^q_rule[RULE_W-1:RULE_DROP_BIT+1];
  um_egress_fifo #(.W(DATA_W), .AW(PKT_DEPTH)) u_pkt_fifo (
    .clk(clk), .aclr(!reset), .data(um2cdp_data), .wrreq(um2cdp_data_valid), .rdreq(pkt_pop),
    .q(q_pkt), .empty(pkt_empty), .usedw(pkt_usedw), .ovf(pkt_ovf)
  );
  um_egress_fifo #(.W(RULE_W), .AW(RULE_DEPTH)) u_rule_fifo (
    .clk(clk), .aclr(!reset), .data(um2cdp_rule), .wrreq(um2cdp_rule_wrreq), .rdreq(rule_pop),
    .q(q_rule), .empty(rule_empty), .usedw(rule_level), .ovf(rule_ovf)
  );
  assign tail = q_pkt[FLAG_LSB+:3] == TAIL;
  assign rule_pop = state == IDLE && !rule_empty && !pkt_empty;
  assign fwd = state == SEND && !pkt_empty && port_ready[port];
  assign pkt_pop = fwd || (state == DROP && !pkt_empty);
  assign sent_done = fwd && tail;
  assign drop_done = state == DROP && !pkt_empty && tail;
  // skip folds the drop bit and an out-of-range port into one flag so DECIDE only adds the head check
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      port <= '0;
      skip <= 1'b0;
    end else begin
      case (state)
        IDLE: if (rule_pop) begin
          port <= q_rule[PW-1:0];
          skip <= q_rule[RULE_DROP_BIT] || 32'(q_rule[RULE_PORT_LSB+:RULE_PORT_W]) >= NPORT;
          state <= DECIDE;
        end
        DECIDE: state <= (skip || q_pkt[FLAG_LSB+:3] != HEAD) ? DROP : SEND;
        SEND: if (sent_done) state <= IDLE;
        DROP: if (drop_done) state <= IDLE;
      endcase
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cdp2um_tx_enable <= 1'b0;
      cdp2um_rule_usedw <= '0;
      err_sticky <= '0;
    end else begin
      cdp2um_tx_enable <= 32'(pkt_usedw) < PKT_AFULL && 32'(rule_level) < RULE_WORDS - 2;
      cdp2um_rule_usedw <= rule_level;
      err_sticky <= err_sticky | {pkt_ovf, rule_ovf};
    end
`ifdef UM_EGRESS_STATS_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sent_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (sent_done) sent_cnt <= sent_cnt + 1'b1;
      if (drop_done) drop_cnt <= drop_cnt + 1'b1;
    end
`else
  assign sent_cnt = '0;
  assign drop_cnt = '0;
`endif
  um_egress_steer #(.NPORT(NPORT), .W(DATA_W), .PW(PW)) u_steer (
    .clk(clk), .reset(reset), .fwd(fwd), .port(port), .data(q_pkt),
    .port_data(port_data), .port_data_valid(port_data_valid)
  );
endmodule
